rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-way resource between eight requesters.
- Internally it keeps a 3-bit owner index, which a 3-to-8 decoder turns into a one-hot grant bus.
- It sits between requester blocks and the shared resource, and sequences ownership with a hold-time limit.
- One clock domain.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant. Legal range 2..256.
- CNT_W, 8: hold-counter width. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, 8: request vector. req[i] high means requester i wants the resource.
- done, input, 1: current owner releases the resource. Sampled only while grant_valid=1.
- grant, output, 8: one-hot grant. All zero when grant_valid=0.
- grant_idx, output, 3: binary index of the current owner. Holds its last value while idle.
- grant_valid, output, 1: a grant is active.
- timeout, output, 1: one-cycle pulse indicating the previous grant was revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE
  - grant_valid=0, grant=8'h00, grant_idx=3'd0, timeout=0
  - rotating pointer ptr=3'd0, hold counter cnt=0
- Registers: state, ptr, grant_idx, cnt, timeout.
- grant is the combinational decode of the registered grant_idx, gated by grant_valid. There is no combinational path from inputs to outputs.
- State IDLE:
  - If req != 0, search starts at ptr and goes upward modulo 8 (ptr, ptr+1, ..., ptr+7). The first set bit wins.
  - At the next edge: grant_idx <= winner, grant_valid <= 1, cnt <= 0, state <= BUSY.
  - If req == 0, stay in IDLE.
- State BUSY: the release condition is evaluated every cycle as rel = done | ~req[grant_idx] | (cnt == MAX_HOLD-1).
  - rel=1: at the next edge state <= IDLE, grant_valid <= 0, ptr <= grant_idx+1 (mod 8, so 7 wraps to 0).
  - rel=0: cnt <= cnt+1.
- Timeout:
  - Set to 1 at the release edge only when done=0, req[grant_idx]=1 and cnt==MAX_HOLD-1. Otherwise 0.
  - It is therefore high for exactly the one IDLE cycle after a forced release.
- Cycle-level guarantees:
  - Request-to-grant latency is 1 edge from IDLE.
  - There is always exactly one IDLE cycle between consecutive grants, even to the same requester.
  - Maximum grant length is MAX_HOLD cycles.
- Simultaneous events:
  - done together with the timeout condition: release occurs, timeout=0.
  - done together with req[grant_idx] dropping: one normal release.
  - New requests arriving during BUSY do not pre-empt the owner. They are considered in the next IDLE cycle.
- Fairness: the previous owner has the lowest priority in the next arbitration. With all eight requesting, each gets a grant within 8 arbitration rounds.
- Reset mid-grant: outputs clear asynchronously at rst_n fall, ptr returns to 0, and no timeout pulse is produced.
- grant_idx values outside 0..7 cannot occur (3-bit), so no illegal-index handling is needed.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=8, IDX_W=3
  - state typedef {IDLE, BUSY}
  - default MAX_HOLD constant
- Sub-module grant_dec_3x8:
  - Purely combinational 3-to-8 one-hot decoder with an enable input (grant_valid).
  - Instantiated once inside rr_arbiter_8.
- Winner search: a rotate-then-priority-encode function local to rr_arbiter_8.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF. Expect grant=8'h00, grant_valid=0, grant_idx=0, timeout=0. Release reset; the first grant goes to idx 0 one edge later.
- Single requester: req=8'h01. Expect grant=8'h01 and idx=0 after 1 edge. Drop req[0]; grant is 8'h00 after the next edge.
- Full rotation: req=8'hFF with done pulsed for one cycle in each grant. Expect idx order 0,1,2,3,4,5,6,7,0, with one idle cycle between grants.
- Wrap-around: obtain a grant to idx 4 and release it (ptr=5). Then req=8'h11. Expect next grant idx=0 (grant=8'h01), then idx=4.
- Timeout with MAX_HOLD=4: req=8'h08 held, done=0.
  - Expect grant_valid high for exactly 4 cycles.
  - Then one idle cycle with timeout=1.
  - Then a re-grant to idx 3.
  - Repeat with done=1 on the 4th cycle: timeout stays 0.
- Reset mid-grant: with grant=8'h20 active, pulse rst_n low between clock edges. Expect grant=8'h00 immediately (before the next edge), and the first post-reset grant to come from a search starting at 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Included by the decoder and the arbiter top.
package arb_pkg;

   localparam int unsigned N_REQ        = 8;
   localparam int unsigned IDX_W        = 3;
   localparam int unsigned MAX_HOLD_DEF = 16;

   typedef enum logic [0:0] {IDLE, BUSY} state_e;

endpackage

// File: rtl/grant_dec_3x8.sv
// 3-to-8 one-hot decoder with enable.
// Drives the grant bus from the registered owner index.
module grant_dec_3x8
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a per-grant hold limit.
// Every output is a register or a decode of registers, so no input reaches an output combinationally.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             cnt_max;
   logic             rel;

   // Rotate so that ptr sits at bit 0, then take the lowest set bit.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] p);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [IDX_W-1:0]   off;
      dbl = {r, r};
      rot = dbl[p +: N_REQ];
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      return p + off;
   endfunction

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      cnt_max   = (cnt_q == CNT_W'(MAX_HOLD - 1));
      rel       = done | ~req[idx_q] | cnt_max;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               idx_d   = rr_pick(req, ptr_q);
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (rel) begin
               state_d   = IDLE;
               ptr_d     = idx_q + 1'b1;
               // Only a revocation the owner did not ask for counts as a timeout.
               timeout_d = ~done & req[idx_q] & cnt_max;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_idx   = idx_q;
   assign timeout     = timeout_q;

   grant_dec_3x8 u_dec (
      .idx    (idx_q),
      .en     (grant_valid),
      .onehot (grant)
   );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with MAX_HOLD=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_chk  = 0;
   int n_pass = 0;

   rr_arbiter_8 #(
      .MAX_HOLD (4),
      .CNT_W    (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] idx);
      logic [7:0] oh;
      oh = 8'h01 << idx;
      chk({tag, ".valid"}, {7'd0, grant_valid}, 8'h01);
      chk({tag, ".idx"}, {5'd0, grant_idx}, {5'd0, idx});
      chk({tag, ".grant"}, grant, oh);
   endtask

   task automatic chk_idle(input string tag, input logic to_exp);
      chk({tag, ".valid"}, {7'd0, grant_valid}, 8'h00);
      chk({tag, ".grant"}, grant, 8'h00);
      chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to_exp});
   endtask

   initial begin
      // Reset with everyone requesting
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      tick();
      tick();
      chk_idle("rst", 1'b0);
      chk("rst.idx", {5'd0, grant_idx}, 8'h00);
      rst_n = 1'b1;
      tick();
      chk_grant("rst_first", 3'd0);
      done = 1'b1;
      tick();
      chk_idle("rst_rel", 1'b0);
      done = 1'b0;
      req  = 8'h00;
      tick();
      chk_idle("idle_noreq", 1'b0);

      // Single requester, released by dropping req (ptr=1 here)
      req = 8'h01;
      tick();
      chk_grant("single", 3'd0);
      req = 8'h00;
      tick();
      chk_idle("single_drop", 1'b0);

      // Park ptr at 0 via a grant to idx 7
      req = 8'h80;
      tick();
      chk_grant("park7", 3'd7);
      req = 8'h00;
      tick();

      // Full rotation 0..7,0 with a one-cycle done in each grant
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk_grant($sformatf("rot%0d", k), 3'(k % 8));
         done = 1'b1;
         tick();
         chk_idle($sformatf("rot%0d_gap", k), 1'b0);
         done = 1'b0;
      end

      // Wrap-around: release idx 4 so ptr=5, then req 0 and 4
      req = 8'h10;
      tick();
      chk_grant("wrap_pre", 3'd4);
      req = 8'h00;
      tick();
      req = 8'h11;
      tick();
      chk_grant("wrap_a", 3'd0);
      done = 1'b1;
      tick();
      chk_idle("wrap_gap", 1'b0);
      done = 1'b0;
      tick();
      chk_grant("wrap_b", 3'd4);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'h00;
      tick();

      // Timeout: held for exactly MAX_HOLD cycles, then one idle with timeout
      req = 8'h08;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_grant($sformatf("hold%0d", c), 3'd3);
         chk("hold.timeout", {7'd0, timeout}, 8'h00);
      end
      tick();
      chk_idle("to_pulse", 1'b1);
      tick();
      chk_grant("to_regrant", 3'd3);
      chk("to_regrant.timeout", {7'd0, timeout}, 8'h00);
      // Same again, but done coincides with the last allowed cycle
      tick();
      tick();
      tick();
      chk_grant("hold_last", 3'd3);
      done = 1'b1;
      tick();
      chk_idle("done_at_max", 1'b0);
      done = 1'b0;
      req  = 8'h00;
      tick();

      // Reset mid-grant: outputs clear before the next edge, ptr returns to 0
      req = 8'h20;
      tick();
      chk("mid.grant", grant, 8'h20);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("mid_rst", 1'b0);
      chk("mid_rst.idx", {5'd0, grant_idx}, 8'h00);
      #2;
      rst_n = 1'b1;
      req   = 8'h82;
      tick();
      chk_grant("post_rst", 3'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
